// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, fault codes,
// FSM state encoding and the funct3 legality helper.
package lsu_pkg;

   // RV32I load funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // RV32I store funct3 encodings
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Writeback fault codes
   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_ACCESS   = 2'b10;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

   // Access size as encoded in funct3[1:0]
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   // An operation flagged as both load and store is treated like a bad funct3
   function automatic logic funct3_illegal(input logic is_load,
                                           input logic is_store,
                                           input logic [2:0] funct3);
      logic bad;
      bad = 1'b0;
      if (is_load && is_store) begin
         bad = 1'b1;
      end else if (is_load) begin
         bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end else if (is_store) begin
         bad = (funct3 > SW);
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane-select and sign/zero extension from a raw memory word.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  ea_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Pick the addressed byte/half from the word, then extend per funct3
   always_comb begin
      lane_byte = 8'h00;
      lane_half = ea_lo[1] ? rdata[31:16] : rdata[15:0];
      case (ea_lo)
         2'd0:    lane_byte = rdata[7:0];
         2'd1:    lane_byte = rdata[15:8];
         2'd2:    lane_byte = rdata[23:16];
         default: lane_byte = rdata[31:24];
      endcase
      case (funct3)
         LB:      data = {{24{lane_byte[7]}}, lane_byte};
         LH:      data = {{16{lane_half[15]}}, lane_half};
         LBU:     data = {24'h000000, lane_byte};
         LHU:     data = {16'h0000, lane_half};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller: accepts one load/store from execute,
// checks it, issues a word-aligned memory request and returns a one-cycle
// writeback with fault code.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses fault; otherwise the address is forced down to natural alignment.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 4096,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_base,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_sdata,
   input  logic [4:0]  ex_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [1:0]  wb_fault,
   output logic [31:0] wb_badaddr
);

   lsu_state_t  state;
   lsu_state_t  next_state;

   logic        op_load;
   logic        op_store;
   logic [2:0]  op_funct3;
   logic [31:0] op_ea;
   logic [31:0] op_sdata;
   logic [4:0]  op_rd;
   logic [1:0]  op_fault;
   logic [31:0] load_data;
   logic [31:0] ack_cnt;

   logic        accept;
   logic [31:0] ea_raw;
   logic [31:0] ea_use;
   logic        acc_illegal;
   logic        acc_access;
   logic [1:0]  acc_fault;
   logic        timeout;
   logic [31:0] aligned_data;

   lsu_load_align u_load_align (
      .rdata  (mem_rdata),
      .ea_lo  (op_ea[1:0]),
      .funct3 (op_funct3),
      .data   (aligned_data)
   );

   // Address generation and fault classification for the offered operation
`ifdef LSU_MISALIGN_TRAP_EN
   logic acc_misalign;

   always_comb begin
      ea_raw       = ex_base + ex_imm;
      ea_use       = ea_raw;
      acc_illegal  = funct3_illegal(ex_is_load, ex_is_store, ex_funct3);
      acc_misalign = ((ex_funct3[1:0] == SIZE_HALF) && ea_raw[0]) ||
                     ((ex_funct3[1:0] == SIZE_WORD) && (ea_raw[1:0] != 2'b00));
      acc_access   = ({2'b00, ea_use[31:2]} >= MEM_WORDS);
      if (acc_illegal)       acc_fault = FAULT_ILLEGAL;
      else if (acc_misalign) acc_fault = FAULT_MISALIGN;
      else if (acc_access)   acc_fault = FAULT_ACCESS;
      else                   acc_fault = FAULT_NONE;
   end
`else
   always_comb begin
      ea_raw      = ex_base + ex_imm;
      ea_use      = ea_raw;
      acc_illegal = funct3_illegal(ex_is_load, ex_is_store, ex_funct3);
      if (!acc_illegal) begin
         if (ex_funct3[1:0] == SIZE_HALF) ea_use[0]   = 1'b0;
         if (ex_funct3[1:0] == SIZE_WORD) ea_use[1:0] = 2'b00;
      end
      acc_access  = ({2'b00, ea_use[31:2]} >= MEM_WORDS);
      if (acc_illegal)     acc_fault = FAULT_ILLEGAL;
      else if (acc_access) acc_fault = FAULT_ACCESS;
      else                 acc_fault = FAULT_NONE;
   end
`endif

   assign accept  = (state == ST_IDLE) && ex_valid && (ex_is_load || ex_is_store);
   assign timeout = (ACK_TIMEOUT != 0) && ((ack_cnt + 32'd1) == ACK_TIMEOUT);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // FSM next-state: faults skip the request, ack beats timeout in REQ
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept) next_state = (acc_fault != FAULT_NONE) ? ST_RESP : ST_REQ;
         end
         ST_REQ: begin
            if (mem_ack || timeout) next_state = ST_RESP;
         end
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Operation capture, load data register and ack timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         op_load   <= 1'b0;
         op_store  <= 1'b0;
         op_funct3 <= 3'b000;
         op_ea     <= 32'h0;
         op_sdata  <= 32'h0;
         op_rd     <= 5'd0;
         op_fault  <= FAULT_NONE;
         load_data <= 32'h0;
         ack_cnt   <= 32'h0;
      end else if (accept) begin
         op_load   <= ex_is_load;
         op_store  <= ex_is_store;
         op_funct3 <= ex_funct3;
         op_ea     <= ea_use;
         op_sdata  <= ex_sdata;
         op_rd     <= ex_rd;
         op_fault  <= acc_fault;
         ack_cnt   <= 32'h0;
      end else if (state == ST_REQ) begin
         if (mem_ack) begin
            load_data <= aligned_data;
         end else begin
            ack_cnt <= ack_cnt + 32'd1;
            if (timeout) op_fault <= FAULT_ACCESS;
         end
      end
   end

   // Outputs decoded from state and the captured operation
   always_comb begin
      ex_ready   = (state == ST_IDLE);
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      mem_wstrb  = 4'b0000;
      mem_wdata  = 32'h0;
      wb_valid   = 1'b0;
      wb_rd      = 5'd0;
      wb_data    = 32'h0;
      wb_fault   = FAULT_NONE;
      wb_badaddr = 32'h0;
      if (state == ST_REQ) begin
         mem_req  = 1'b1;
         mem_we   = op_store;
         mem_addr = {op_ea[31:2], 2'b00};
         if (op_store) begin
            case (op_funct3)
               SB: begin
                  mem_wdata = {4{op_sdata[7:0]}};
                  mem_wstrb = 4'b0001 << op_ea[1:0];
               end
               SH: begin
                  mem_wdata = {2{op_sdata[15:0]}};
                  mem_wstrb = 4'b0011 << {op_ea[1], 1'b0};
               end
               default: begin
                  mem_wdata = op_sdata;
                  mem_wstrb = 4'b1111;
               end
            endcase
         end
      end
      if (state == ST_RESP) begin
         wb_valid = 1'b1;
         wb_fault = op_fault;
         if (op_fault != FAULT_NONE) begin
            wb_badaddr = op_ea;
         end else if (op_load) begin
            wb_rd   = op_rd;
            wb_data = load_data;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed operations push expected
// memory requests and writebacks; a negedge monitor pops and compares.
module tb_lsu_mem_ctrl;

   localparam int ACK_TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_base, ex_imm, ex_sdata;
   logic [4:0]  ex_rd;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, wb_badaddr;
   logic [1:0]  wb_fault;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [1:0]  fault;
      logic [31:0] bad;
   } wb_t;

   req_t  req_q[$];
   wb_t   wb_q[$];
   string req_name_q[$];
   string wb_name_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  req_seen = 1'b0;

   lsu_mem_ctrl #(.MEM_WORDS(4096), .ACK_TIMEOUT(ACK_TO)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_base(ex_base), .ex_imm(ex_imm),
      .ex_sdata(ex_sdata), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_fault(wb_fault), .wb_badaddr(wb_badaddr)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic req_t mk_req(input logic [31:0] addr, input logic we,
                                   input logic [3:0] wstrb, input logic [31:0] wdata);
      req_t r;
      r.addr = addr; r.we = we; r.wstrb = wstrb; r.wdata = wdata;
      return r;
   endfunction

   function automatic wb_t mk_wb(input logic [4:0] rd, input logic [31:0] data,
                                 input logic [1:0] fault, input logic [31:0] bad);
      wb_t w;
      w.rd = rd; w.data = data; w.fault = fault; w.bad = bad;
      return w;
   endfunction

   // Monitor: compares each new memory request and each writeback pulse
   always @(negedge clk) begin
      req_t  r;
      wb_t   w;
      string n;
      if (reset) begin
         req_seen = 1'b0;
      end else begin
         if (mem_req && !req_seen) begin
            if (req_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_req actual addr=0x%08h required none", mem_addr);
            end else begin
               r = req_q.pop_front();
               n = req_name_q.pop_front();
               check_output({n, ".addr"},  mem_addr, r.addr);
               check_output({n, ".we"},    {31'd0, mem_we}, {31'd0, r.we});
               check_output({n, ".wstrb"}, {28'd0, mem_wstrb}, {28'd0, r.wstrb});
               check_output({n, ".wdata"}, mem_wdata, r.wdata);
            end
         end
         req_seen = mem_req;
         if (wb_valid) begin
            if (wb_q.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_wb actual fault=%0d required none", wb_fault);
            end else begin
               w = wb_q.pop_front();
               n = wb_name_q.pop_front();
               check_output({n, ".wb_rd"},    {27'd0, wb_rd}, {27'd0, w.rd});
               check_output({n, ".wb_data"},  wb_data, w.data);
               check_output({n, ".wb_fault"}, {30'd0, wb_fault}, {30'd0, w.fault});
               check_output({n, ".wb_bad"},   wb_badaddr, w.bad);
            end
         end
      end
   end

   // Issue one operation, play the memory side, and check handshake timing
   task automatic apply_stimulus(input string name, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [31:0] base,
                                 input logic [31:0] imm, input logic [31:0] sd,
                                 input logic [4:0] rd, input int ack_delay,
                                 input logic [31:0] rdata, input logic exp_req,
                                 input req_t er, input wb_t ew);
      int   n;
      int   rc;
      int   ack_at;
      int   exp_rc;
      logic busy_ok;
      if (exp_req) begin
         req_q.push_back(er);
         req_name_q.push_back(name);
      end
      wb_q.push_back(ew);
      wb_name_q.push_back(name);
      n = 0;
      while (!ex_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
      ex_base = base; ex_imm = imm; ex_sdata = sd; ex_rd = rd;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      check_output({name, ".busy"}, {31'd0, ex_ready}, 32'd0);
      check_output({name, ".req_latency"}, {31'd0, mem_req}, {31'd0, exp_req});
      rc = 0; n = 0; ack_at = -1; busy_ok = 1'b1;
      while (!wb_valid && n < 60) begin
         if (ex_ready) busy_ok = 1'b0;
         if (mem_req) begin
            rc++;
            if (ack_delay >= 0 && rc == ack_delay + 1) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
               ack_at = n;
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_rdata = 32'h0;
         n++;
      end
      exp_rc = exp_req ? ((ack_delay >= 0) ? ack_delay + 1 : ACK_TO) : 0;
      check_output({name, ".wb_seen"}, {31'd0, wb_valid}, 32'd1);
      check_output({name, ".req_cycles"}, rc, exp_rc);
      if (ack_at >= 0) check_output({name, ".ack_to_wb"}, n - ack_at, 32'd1);
      check_output({name, ".busy_hold"}, {31'd0, busy_ok}, 32'd1);
      @(posedge clk); #1;
      check_output({name, ".ready_after"}, {31'd0, ex_ready}, 32'd1);
      check_output({name, ".wb_pulse"}, {31'd0, wb_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      ex_funct3 = 3'b000; ex_base = 32'h0; ex_imm = 32'h0; ex_sdata = 32'h0;
      ex_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset.ex_ready", {31'd0, ex_ready}, 32'd1);
      check_output("reset.mem_req",  {31'd0, mem_req}, 32'd0);
      check_output("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
      check_output("reset.mem_addr", mem_addr, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Stray ack and a non-memory offer in IDLE must do nothing
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check_output("idle.ex_ready", {31'd0, ex_ready}, 32'd1);
      check_output("idle.mem_req",  {31'd0, mem_req}, 32'd0);
      check_output("idle.wb_valid", {31'd0, wb_valid}, 32'd0);

      apply_stimulus("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd5, 1, 32'h0,
                     1'b1, mk_req(32'h104, 1'b1, 4'hF, 32'hDEADBEEF), mk_wb(5'd0, 32'h0, 2'b00, 32'h0));
      apply_stimulus("lb", 1'b1, 1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd7, 0, 32'h80AABBCC,
                     1'b1, mk_req(32'h200, 1'b0, 4'h0, 32'h0), mk_wb(5'd7, 32'hFFFFFF80, 2'b00, 32'h0));
      apply_stimulus("lbu", 1'b1, 1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd7, 2, 32'h80AABBCC,
                     1'b1, mk_req(32'h200, 1'b0, 4'h0, 32'h0), mk_wb(5'd7, 32'h00000080, 2'b00, 32'h0));
      apply_stimulus("sh", 1'b0, 1'b1, 3'b001, 32'h10, 32'h2, 32'hABCD1234, 5'd0, 0, 32'h0,
                     1'b1, mk_req(32'h10, 1'b1, 4'hC, 32'h12341234), mk_wb(5'd0, 32'h0, 2'b00, 32'h0));
      apply_stimulus("lhu", 1'b1, 1'b0, 3'b101, 32'h10, 32'h2, 32'h0, 5'd3, 1, 32'h5678ABCD,
                     1'b1, mk_req(32'h10, 1'b0, 4'h0, 32'h0), mk_wb(5'd3, 32'h00005678, 2'b00, 32'h0));
      apply_stimulus("lh", 1'b1, 1'b0, 3'b001, 32'h10, 32'h2, 32'h0, 5'd4, 0, 32'h80010000,
                     1'b1, mk_req(32'h10, 1'b0, 4'h0, 32'h0), mk_wb(5'd4, 32'hFFFF8001, 2'b00, 32'h0));
      apply_stimulus("sb", 1'b0, 1'b1, 3'b000, 32'h30, 32'h1, 32'h000000A5, 5'd1, 0, 32'h0,
                     1'b1, mk_req(32'h30, 1'b1, 4'h2, 32'hA5A5A5A5), mk_wb(5'd0, 32'h0, 2'b00, 32'h0));
      apply_stimulus("lw_negimm", 1'b1, 1'b0, 3'b010, 32'h108, 32'hFFFFFFFC, 32'h0, 5'd31, 0, 32'hCAFEF00D,
                     1'b1, mk_req(32'h104, 1'b0, 4'h0, 32'h0), mk_wb(5'd31, 32'hCAFEF00D, 2'b00, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
      apply_stimulus("lw_mis", 1'b1, 1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd4, 0, 32'h11223344,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b01, 32'h101));
      apply_stimulus("sh_mis", 1'b0, 1'b1, 3'b001, 32'h10, 32'h3, 32'h0000BEEF, 5'd0, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b01, 32'h13));
      apply_stimulus("mis_over_acc", 1'b1, 1'b0, 3'b010, 32'h4001, 32'h0, 32'h0, 5'd4, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b01, 32'h4001));
`else
      apply_stimulus("lw_mis", 1'b1, 1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd4, 0, 32'h11223344,
                     1'b1, mk_req(32'h100, 1'b0, 4'h0, 32'h0), mk_wb(5'd4, 32'h11223344, 2'b00, 32'h0));
      apply_stimulus("sh_mis", 1'b0, 1'b1, 3'b001, 32'h10, 32'h3, 32'h0000BEEF, 5'd0, 0, 32'h0,
                     1'b1, mk_req(32'h10, 1'b1, 4'hC, 32'hBEEFBEEF), mk_wb(5'd0, 32'h0, 2'b00, 32'h0));
`endif
      apply_stimulus("lw_range", 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 5'd2, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b10, 32'h4000));
      apply_stimulus("lw_top", 1'b1, 1'b0, 3'b010, 32'h3FFC, 32'h0, 32'h0, 5'd2, 0, 32'h0BADF00D,
                     1'b1, mk_req(32'h3FFC, 1'b0, 4'h0, 32'h0), mk_wb(5'd2, 32'h0BADF00D, 2'b00, 32'h0));
      apply_stimulus("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 5'd2, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b11, 32'h20));
      apply_stimulus("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h24, 32'h0, 32'h0, 5'd0, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b11, 32'h24));
      apply_stimulus("ld_and_st", 1'b1, 1'b1, 3'b010, 32'h28, 32'h0, 32'h0, 5'd2, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b11, 32'h28));
      apply_stimulus("ill_over_acc", 1'b1, 1'b0, 3'b111, 32'h8000, 32'h0, 32'h0, 5'd2, 0, 32'h0,
                     1'b0, mk_req(32'h0, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b11, 32'h8000));
      apply_stimulus("timeout", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 5'd6, -1, 32'h0,
                     1'b1, mk_req(32'h50, 1'b0, 4'h0, 32'h0), mk_wb(5'd0, 32'h0, 2'b10, 32'h50));
      apply_stimulus("ack_at_limit", 1'b1, 1'b0, 3'b010, 32'h54, 32'h0, 32'h0, 5'd6, 15, 32'h13579BDF,
                     1'b1, mk_req(32'h54, 1'b0, 4'h0, 32'h0), mk_wb(5'd6, 32'h13579BDF, 2'b00, 32'h0));

      // Reset while a request is outstanding: request dropped, no writeback
      req_q.push_back(mk_req(32'h60, 1'b0, 4'h0, 32'h0));
      req_name_q.push_back("rst_req");
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_base = 32'h60; ex_imm = 32'h0; ex_rd = 5'd8;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_load = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_output("rst.req_before", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_output("rst.mem_req",  {31'd0, mem_req}, 32'd0);
      check_output("rst.ex_ready", {31'd0, ex_ready}, 32'd1);
      check_output("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
      n = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (wb_valid) n++;
      end
      check_output("rst.no_wb", n, 32'd0);

      apply_stimulus("after_rst", 1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 32'h0, 5'd8, 0, 32'h2468ACE0,
                     1'b1, mk_req(32'h60, 1'b0, 4'h0, 32'h0), mk_wb(5'd8, 32'h2468ACE0, 2'b00, 32'h0));

      repeat (2) @(posedge clk);
      #1;
      check_output("req_queue_empty", req_q.size(), 32'd0);
      check_output("wb_queue_empty", wb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
